// File: rtl/hazard_scoreboard_ctrl_if.sv
// Bundles the pipeline-side signals of the hazard/scoreboard controller.
//   master : pipeline side (drives ID/EXE/bypass info and redirect events, receives controls)
//   slave  : the controller itself
// Signal groups:
//   redirect events   wfi_i, mret_i, trap_valid_i, interrupt_taken_i, BU_flush_i
//   ID uOP            id_valid_i, id_src_{use,fp,idx}_i, id_rd_{we,fp}_i, id_rd_i, id_lat_i
//   bypass stages     stg_we_i, stg_rd_fp_i, stg_rd_i (stage 1 = bit/slice 0 = youngest)
//   EXE uOP sources   exe_src_{use,fp,idx}_i
//   controls out      fwd_sel_o, stall_o, booting_o, waiting_o, draining_o,
//                     flush_{if,id,exe,mem}_o, sb_full_o
interface hazard_scoreboard_ctrl_if #(
    parameter int NUM_SRC    = 3,
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 2,
    parameter int MAX_LAT    = 7
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic                          wfi_i;
    logic                          mret_i;
    logic                          trap_valid_i;
    logic                          interrupt_taken_i;
    logic                          BU_flush_i;
    logic                          id_valid_i;
    logic [NUM_SRC-1:0]            id_src_use_i;
    logic [NUM_SRC-1:0]            id_src_fp_i;
    logic [NUM_SRC*REG_W-1:0]      id_src_idx_i;
    logic                          id_rd_we_i;
    logic                          id_rd_fp_i;
    logic [REG_W-1:0]              id_rd_i;
    logic [LAT_W-1:0]              id_lat_i;
    logic [FWD_STAGES-1:0]         stg_we_i;
    logic [FWD_STAGES-1:0]         stg_rd_fp_i;
    logic [FWD_STAGES*REG_W-1:0]   stg_rd_i;
    logic [NUM_SRC-1:0]            exe_src_use_i;
    logic [NUM_SRC-1:0]            exe_src_fp_i;
    logic [NUM_SRC*REG_W-1:0]      exe_src_idx_i;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o;
    logic                          stall_o;
    logic                          booting_o;
    logic                          waiting_o;
    logic                          draining_o;
    logic                          flush_if_o;
    logic                          flush_id_o;
    logic                          flush_exe_o;
    logic                          flush_mem_o;
    logic                          sb_full_o;

    modport master (
        output wfi_i, mret_i, trap_valid_i, interrupt_taken_i, BU_flush_i,
               id_valid_i, id_src_use_i, id_src_fp_i, id_src_idx_i,
               id_rd_we_i, id_rd_fp_i, id_rd_i, id_lat_i,
               stg_we_i, stg_rd_fp_i, stg_rd_i,
               exe_src_use_i, exe_src_fp_i, exe_src_idx_i,
        input  fwd_sel_o, stall_o, booting_o, waiting_o, draining_o,
               flush_if_o, flush_id_o, flush_exe_o, flush_mem_o, sb_full_o
    );

    modport slave (
        input  wfi_i, mret_i, trap_valid_i, interrupt_taken_i, BU_flush_i,
               id_valid_i, id_src_use_i, id_src_fp_i, id_src_idx_i,
               id_rd_we_i, id_rd_fp_i, id_rd_i, id_lat_i,
               stg_we_i, stg_rd_fp_i, stg_rd_i,
               exe_src_use_i, exe_src_fp_i, exe_src_idx_i,
        output fwd_sel_o, stall_o, booting_o, waiting_o, draining_o,
               flush_if_o, flush_id_o, flush_exe_o, flush_mem_o, sb_full_o
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline controller beside ID: run-state FSM (BOOTING/OPERATING/DRAIN/WFI), stage flushes,
// per-source bypass select for the EXE operand muxes, and a scoreboard of in-flight
// multi-cycle producers that stalls dependent / WAW uOPs in ID.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    hazard_scoreboard_ctrl_if.slave (ID/EXE/bypass inputs, stall/flush/fwd outputs)
module hazard_scoreboard_ctrl #(
    parameter int NUM_SRC    = 3,
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 2,
    parameter int SB_DEPTH   = 4,
    parameter int MAX_LAT    = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    hazard_scoreboard_ctrl_if.slave  bus
);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    localparam logic [1:0] ST_BOOTING   = 2'd0;
    localparam logic [1:0] ST_OPERATING = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;
    localparam logic [1:0] ST_WFI       = 2'd3;

    logic [1:0]                         r_state;
    logic [1:0]                         w_state_nxt;
    logic [SB_DEPTH-1:0]                r_sb_v;
    logic [SB_DEPTH-1:0]                r_sb_fp;
    logic [SB_DEPTH-1:0][REG_W-1:0]     r_sb_rd;
    logic [SB_DEPTH-1:0][LAT_W-1:0]     r_sb_cnt;

    logic                               w_operating;
    logic                               w_sb_full;
    logic                               w_sb_empty;
    logic                               w_rd_live;
    logic                               w_src_hit;
    logic                               w_waw;
    logic                               w_stall;
    logic                               w_issue;
    logic                               w_alloc;
    logic                               w_free_found;
    logic [IDX_W-1:0]                   w_free_idx;
    logic [NUM_SRC-1:0][SEL_W-1:0]      w_fwd_sel;
    logic                               w_flush_if;

    // x0 is hard-wired zero: an INT index 0 never creates a dependency.
    function automatic logic f_live(input logic en, input logic fp, input logic [REG_W-1:0] idx);
        return en & (fp | (idx != '0));
    endfunction

    assign w_operating = (r_state == ST_OPERATING);
    assign w_sb_full   = &r_sb_v;
    assign w_sb_empty  = ~|r_sb_v;
    assign w_rd_live   = f_live(bus.id_rd_we_i, bus.id_rd_fp_i, bus.id_rd_i);

    // RAW and WAW checks against every in-flight producer. Entries are only ever
    // allocated for live destinations, so the valid bit is all the liveness they need.
    always_comb begin
        w_src_hit = 1'b0;
        w_waw     = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (r_sb_v[e]) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (f_live(bus.id_src_use_i[k], bus.id_src_fp_i[k],
                               bus.id_src_idx_i[k*REG_W +: REG_W]) &&
                        (bus.id_src_fp_i[k] == r_sb_fp[e]) &&
                        (bus.id_src_idx_i[k*REG_W +: REG_W] == r_sb_rd[e]))
                        w_src_hit = 1'b1;
                end
                if (w_rd_live && (bus.id_rd_fp_i == r_sb_fp[e]) && (bus.id_rd_i == r_sb_rd[e]))
                    w_waw = 1'b1;
            end
        end
    end

    assign w_stall = bus.id_valid_i & w_operating &
                     (w_src_hit | w_waw | ((bus.id_lat_i != '0) & w_rd_live & w_sb_full));

    // Lowest free entry; uses registered valids so a slot retiring this cycle is not reused.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int e = SB_DEPTH - 1; e >= 0; e--) begin
            if (!r_sb_v[e]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(e);
            end
        end
    end

    assign w_flush_if = bus.trap_valid_i | bus.mret_i | bus.BU_flush_i;
    assign w_issue    = bus.id_valid_i & ~w_stall & w_operating & ~w_flush_if;
    assign w_alloc    = w_issue & w_rd_live & (bus.id_lat_i != '0) & w_free_found;

    // Scanning oldest-to-youngest lets the youngest matching stage overwrite the select.
    always_comb begin
        w_fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = FWD_STAGES; s >= 1; s--) begin
                if (f_live(bus.exe_src_use_i[k], bus.exe_src_fp_i[k],
                           bus.exe_src_idx_i[k*REG_W +: REG_W]) &&
                    f_live(bus.stg_we_i[s-1], bus.stg_rd_fp_i[s-1],
                           bus.stg_rd_i[(s-1)*REG_W +: REG_W]) &&
                    (bus.exe_src_fp_i[k] == bus.stg_rd_fp_i[s-1]) &&
                    (bus.exe_src_idx_i[k*REG_W +: REG_W] == bus.stg_rd_i[(s-1)*REG_W +: REG_W]))
                    w_fwd_sel[k] = SEL_W'(s);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOTING:   w_state_nxt = ST_OPERATING;
            ST_OPERATING: if (bus.wfi_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.interrupt_taken_i || bus.trap_valid_i) w_state_nxt = ST_OPERATING;
                else if (w_sb_empty)                           w_state_nxt = ST_WFI;
            end
            ST_WFI:       if (bus.interrupt_taken_i) w_state_nxt = ST_OPERATING;
            default:      w_state_nxt = ST_BOOTING;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BOOTING;
            r_sb_v  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.trap_valid_i) begin
                r_sb_v <= '0;
            end else begin
                // An entry retires at the end of its cnt==1 cycle: its result is on the bypass net.
                for (int e = 0; e < SB_DEPTH; e++) begin
                    if (r_sb_v[e]) begin
                        if (r_sb_cnt[e] == LAT_W'(1)) r_sb_v[e] <= 1'b0;
                        r_sb_cnt[e] <= r_sb_cnt[e] - LAT_W'(1);
                    end
                end
                if (w_alloc) begin
                    r_sb_v[w_free_idx]   <= 1'b1;
                    r_sb_fp[w_free_idx]  <= bus.id_rd_fp_i;
                    r_sb_rd[w_free_idx]  <= bus.id_rd_i;
                    r_sb_cnt[w_free_idx] <= bus.id_lat_i;
                end
            end
        end
    end

    assign bus.fwd_sel_o   = w_fwd_sel;
    assign bus.stall_o     = w_stall;
    assign bus.booting_o   = (r_state == ST_BOOTING);
    assign bus.waiting_o   = (r_state == ST_WFI);
    assign bus.draining_o  = (r_state == ST_DRAIN);
    assign bus.flush_if_o  = w_flush_if;
    assign bus.flush_id_o  = w_flush_if | w_stall | bus.wfi_i | ~w_operating;
    assign bus.flush_exe_o = bus.trap_valid_i;
    assign bus.flush_mem_o = bus.trap_valid_i;
    assign bus.sb_full_o   = w_sb_full;
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
module tb_hazard_scoreboard_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_scoreboard_ctrl_if bus_if ();

    hazard_scoreboard_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then applied for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.wfi_i = 0;            bus_if.mret_i = 0;
        bus_if.trap_valid_i = 0;     bus_if.interrupt_taken_i = 0;
        bus_if.BU_flush_i = 0;       bus_if.id_valid_i = 0;
        bus_if.id_src_use_i = '0;    bus_if.id_src_fp_i = '0;
        bus_if.id_src_idx_i = '0;    bus_if.id_rd_we_i = 0;
        bus_if.id_rd_fp_i = 0;       bus_if.id_rd_i = '0;
        bus_if.id_lat_i = '0;        bus_if.stg_we_i = '0;
        bus_if.stg_rd_fp_i = '0;     bus_if.stg_rd_i = '0;
        bus_if.exe_src_use_i = '0;   bus_if.exe_src_fp_i = '0;
        bus_if.exe_src_idx_i = '0;
    endtask

    task automatic uop(input logic [2:0] use_m, input logic [2:0] fp_m,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic we, input logic rfp, input logic [4:0] rd,
                       input logic [2:0] lat);
        bus_if.id_valid_i   = 1;
        bus_if.id_src_use_i = use_m;
        bus_if.id_src_fp_i  = fp_m;
        bus_if.id_src_idx_i = {s2, s1, s0};
        bus_if.id_rd_we_i   = we;
        bus_if.id_rd_fp_i   = rfp;
        bus_if.id_rd_i      = rd;
        bus_if.id_lat_i     = lat;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1;

        // reset held 3 cycles
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_booting", 32'(bus_if.booting_o), 1);
        chk("rst_stall", 32'(bus_if.stall_o), 0);
        chk("rst_sb_full", 32'(bus_if.sb_full_o), 0);
        chk("rst_fwd_sel", 32'(bus_if.fwd_sel_o), 0);
        chk("rst_waiting", 32'(bus_if.waiting_o), 0);
        chk("rst_draining", 32'(bus_if.draining_o), 0);
        chk("rst_flush_id", 32'(bus_if.flush_id_o), 1);
        tick();
        rst = 0;
        @(negedge clk);
        chk("boot_cycle", 32'(bus_if.booting_o), 1);
        tick();
        @(negedge clk);
        chk("op_booting", 32'(bus_if.booting_o), 0);
        chk("op_flush_id", 32'(bus_if.flush_id_o), 0);
        chk("op_sb_full", 32'(bus_if.sb_full_o), 0);

        // MUL x5 lat=3, then WAW on x5, then readers of x5
        tick();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 5, 3);
        @(negedge clk);
        chk("mul_issue_stall", 32'(bus_if.stall_o), 0);
        tick();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 5, 0);
        @(negedge clk);
        chk("waw_stall", 32'(bus_if.stall_o), 1);
        chk("waw_flush_id", 32'(bus_if.flush_id_o), 1);
        tick();
        uop(3'b001, 3'b000, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("raw_stall_2", 32'(bus_if.stall_o), 1);
        tick();
        @(negedge clk);
        chk("raw_stall_cnt1", 32'(bus_if.stall_o), 1);
        tick();
        @(negedge clk);
        chk("raw_issue", 32'(bus_if.stall_o), 0);
        tick();
        idle();
        bus_if.stg_we_i = 2'b01;
        bus_if.stg_rd_i = {5'd0, 5'd5};
        bus_if.exe_src_use_i = 3'b001;
        bus_if.exe_src_idx_i = {5'd0, 5'd0, 5'd5};
        @(negedge clk);
        chk("mul_fwd_sel", 32'(bus_if.fwd_sel_o), 1);

        // fill the scoreboard: x1..x4 lat=7 issue, x5 stalls until entry 0 retires
        for (int r = 1; r <= 4; r++) begin
            tick();
            idle();
            uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 5'(r), 7);
            @(negedge clk);
            chk("fill_stall", 32'(bus_if.stall_o), 0);
            chk("fill_not_full", 32'(bus_if.sb_full_o), 0);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 5, 7);
            @(negedge clk);
            chk("full_flag", 32'(bus_if.sb_full_o), 1);
            chk("full_stall", 32'(bus_if.stall_o), 1);
        end
        tick();
        @(negedge clk);
        chk("full_freed", 32'(bus_if.sb_full_o), 0);
        chk("full_5th_issue", 32'(bus_if.stall_o), 0);
        tick();
        idle();
        for (int c = 0; c < 10; c++) tick();

        // forwarding: MEM and WB both write f3
        bus_if.stg_we_i = 2'b11;
        bus_if.stg_rd_fp_i = 2'b11;
        bus_if.stg_rd_i = {5'd3, 5'd3};
        bus_if.exe_src_use_i = 3'b010;
        bus_if.exe_src_fp_i = 3'b010;
        bus_if.exe_src_idx_i = {5'd0, 5'd3, 5'd0};
        #1;
        chk("fwd_fp_youngest", 32'(bus_if.fwd_sel_o), 32'h4);
        bus_if.exe_src_fp_i = 3'b000;
        #1;
        chk("fwd_int_vs_fp", 32'(bus_if.fwd_sel_o), 0);
        bus_if.exe_src_fp_i = 3'b010;
        bus_if.stg_we_i = 2'b10;
        #1;
        chk("fwd_wb_only", 32'(bus_if.fwd_sel_o), 32'h8);
        bus_if.stg_we_i = 2'b11;
        bus_if.stg_rd_fp_i = 2'b00;
        bus_if.stg_rd_i = {5'd0, 5'd7};
        bus_if.exe_src_use_i = 3'b011;
        bus_if.exe_src_fp_i = 3'b000;
        bus_if.exe_src_idx_i = {5'd0, 5'd0, 5'd7};
        #1;
        chk("fwd_x0_none", 32'(bus_if.fwd_sel_o), 1);

        // WFI with two pending entries
        tick();
        idle();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 6, 2);
        tick();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 7, 4);
        tick();
        idle();
        bus_if.wfi_i = 1;
        @(negedge clk);
        chk("wfi_not_yet_drain", 32'(bus_if.draining_o), 0);
        chk("wfi_flush_id", 32'(bus_if.flush_id_o), 1);
        tick();
        bus_if.wfi_i = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("draining", 32'(bus_if.draining_o), 1);
            chk("drain_not_waiting", 32'(bus_if.waiting_o), 0);
            tick();
        end
        @(negedge clk);
        chk("waiting", 32'(bus_if.waiting_o), 1);
        chk("waiting_flush_id", 32'(bus_if.flush_id_o), 1);
        tick();
        bus_if.interrupt_taken_i = 1;
        @(negedge clk);
        chk("wake_cycle_waiting", 32'(bus_if.waiting_o), 1);
        tick();
        bus_if.interrupt_taken_i = 0;
        @(negedge clk);
        chk("woken_waiting", 32'(bus_if.waiting_o), 0);
        chk("woken_draining", 32'(bus_if.draining_o), 0);
        chk("woken_flush_id", 32'(bus_if.flush_id_o), 0);

        // trap with stall and 3 pending
        for (int r = 1; r <= 3; r++) begin
            tick();
            uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 5'(r), 7);
        end
        tick();
        uop(3'b001, 3'b000, 2, 0, 0, 0, 0, 0, 0);
        bus_if.trap_valid_i = 1;
        @(negedge clk);
        chk("trap_stall", 32'(bus_if.stall_o), 1);
        chk("trap_flush_if", 32'(bus_if.flush_if_o), 1);
        chk("trap_flush_id", 32'(bus_if.flush_id_o), 1);
        chk("trap_flush_exe", 32'(bus_if.flush_exe_o), 1);
        chk("trap_flush_mem", 32'(bus_if.flush_mem_o), 1);
        tick();
        bus_if.trap_valid_i = 0;
        @(negedge clk);
        chk("post_trap_stall", 32'(bus_if.stall_o), 0);
        chk("post_trap_flush_exe", 32'(bus_if.flush_exe_o), 0);

        // mret flush suppresses allocation
        tick();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 8, 7);
        bus_if.mret_i = 1;
        @(negedge clk);
        chk("mret_flush_if", 32'(bus_if.flush_if_o), 1);
        tick();
        bus_if.mret_i = 0;
        uop(3'b001, 3'b000, 8, 0, 0, 1, 0, 8, 0);
        @(negedge clk);
        chk("mret_no_alloc", 32'(bus_if.stall_o), 0);

        // reset in the middle of a drain
        tick();
        uop(3'b000, 3'b000, 0, 0, 0, 1, 0, 9, 7);
        tick();
        idle();
        bus_if.wfi_i = 1;
        tick();
        bus_if.wfi_i = 0;
        rst = 1;
        @(negedge clk);
        chk("pre_rst_draining", 32'(bus_if.draining_o), 1);
        tick();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_booting", 32'(bus_if.booting_o), 1);
        chk("mid_rst_draining", 32'(bus_if.draining_o), 0);
        tick();
        uop(3'b001, 3'b000, 9, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_sb_cleared", 32'(bus_if.stall_o), 0);
        chk("mid_rst_operating", 32'(bus_if.booting_o), 0);

        tick();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
